// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port plus
// the valid/ready instruction stream towards the datapath.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [31:0]           mem_rdata_i;
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;
  logic                  instr_valid_o;
  logic [31:0]           instr_o;
  logic [ADDR_WIDTH-1:0] instr_pc_o;
  logic                  instr_ready_i;
  logic                  protocol_err_o;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i,
    input  redirect_i,
    input  redirect_pc_i,
    output instr_valid_o,
    output instr_o,
    output instr_pc_o,
    input  instr_ready_i,
    output protocol_err_o
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i,
    output redirect_i,
    output redirect_pc_i,
    input  instr_valid_o,
    input  instr_o,
    input  instr_pc_o,
    output instr_ready_i,
    input  protocol_err_o
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Pipelined instruction fetch: credit-limited requests,
// in-order prefetch FIFO, redirect with in-flight discard.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  instr_fetch_unit_if.master  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [31:0]           data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         discard;
  logic                  err;

  logic [CW:0]           inflight;
  logic                  req;
  logic                  issue;
  logic                  resp;
  logic                  drop;
  logic                  push;
  logic                  pop;
  logic [CW-1:0]         out_nxt;

  // Handshake decode: credits, accepted responses,
  // pushes and pops for this cycle.
  always_comb begin
    inflight = {1'b0, count} + {1'b0, outstanding};
    req      = rst_i && !bus.redirect_i
               && (inflight < (CW+1)'(DEPTH));
    issue    = req && bus.mem_gnt_i;
    resp     = bus.mem_rvalid_i
               && ((outstanding != '0) || issue);
    drop     = resp && (discard != '0);
    push     = resp && !drop && !bus.redirect_i;
    pop      = (count != '0) && bus.instr_ready_i
               && !bus.redirect_i;
    out_nxt  = outstanding + CW'(issue) - CW'(resp);
  end

  assign bus.mem_req_o      = req;
  assign bus.mem_addr_o     = fetch_pc;
  assign bus.instr_valid_o  = (count != '0);
  assign bus.instr_o        = data_q[rd_ptr];
  assign bus.instr_pc_o     = pc_q[rd_ptr];
  assign bus.protocol_err_o = err;

  // Request side: fetch PC, outstanding/discard
  // bookkeeping and the sticky protocol error.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      err         <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      if (bus.redirect_i) begin
        fetch_pc <= bus.redirect_pc_i;
        // everything still in flight is stale
        discard  <= out_nxt;
      end else begin
        if (issue)
          fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        if (drop)
          discard <= discard - CW'(1);
      end
      if (bus.mem_rvalid_i && !resp)
        err <= 1'b1;
    end
  end

  // Prefetch FIFO: in-order push of responses with
  // their PC, pop on handshake, flush on redirect.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      resp_pc <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (bus.redirect_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      resp_pc <= bus.redirect_pc_i;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= bus.mem_rdata_i;
        pc_q[wr_ptr]   <= resp_pc;
        wr_ptr         <= wr_ptr + PW'(1);
        resp_pc        <= resp_pc + ADDR_WIDTH'(4);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a
// fixed-latency in-order instruction memory model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic man_rv = 1'b0;
  int   lat = 1;
  int   tests = 0;
  int   fails = 0;
  int   ngnt;
  logic [3:0] pv;
  logic [7:0] pa [4];
  bit   ok;

  instr_fetch_unit_if #(.ADDR_WIDTH(8)) bus ();

  instr_fetch_unit #(
    .ADDR_WIDTH(8),
    .DEPTH(4),
    .RESET_PC(8'h00)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] dat(logic [7:0] a);
    return {8'hA5, a, ~a, 8'h3C};
  endfunction

  // memory model: response lat cycles after grant
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0;
      for (int i = 0; i < 4; i++) pa[i] <= '0;
      ngnt <= 0;
    end else begin
      pv    <= {pv[2:0], bus.mem_req_o && bus.mem_gnt_i};
      pa[0] <= bus.mem_addr_o;
      for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
      if (bus.mem_req_o && bus.mem_gnt_i) ngnt <= ngnt + 1;
    end
  end

  assign bus.mem_rvalid_i = pv[lat-1] | man_rv;
  assign bus.mem_rdata_i  = pv[lat-1] ? dat(pa[lat-1])
                                      : 32'hDEAD_BEEF;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int l);
    rst = 1'b0;
    lat = l;
    man_rv = 1'b0;
    bus.mem_gnt_i = 1'b1;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 8'h00;
    bus.instr_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic wait_valid(string tag);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (bus.instr_valid_o) ok = 1'b1;
      else step();
    end
    chk({tag, "_timeout"}, 32'(ok), 32'd1);
  endtask

  initial begin
    bus.mem_gnt_i = 1'b1;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 8'h00;
    bus.instr_ready_i = 1'b1;

    // reset values
    #12;
    chk("rst_req", 32'(bus.mem_req_o), 0);
    chk("rst_valid", 32'(bus.instr_valid_o), 0);
    chk("rst_instr", bus.instr_o, 0);
    chk("rst_pc", 32'(bus.instr_pc_o), 0);
    chk("rst_err", 32'(bus.protocol_err_o), 0);

    // streaming, latency 1, ready high
    do_reset(1);
    chk("s_req0", 32'(bus.mem_req_o), 1);
    chk("s_addr0", 32'(bus.mem_addr_o), 0);
    step();
    chk("s_addr1", 32'(bus.mem_addr_o), 4);
    chk("s_valid1", 32'(bus.instr_valid_o), 0);
    step();
    chk("s_valid2", 32'(bus.instr_valid_o), 1);
    chk("s_pc2", 32'(bus.instr_pc_o), 0);
    chk("s_data2", bus.instr_o, dat(8'h00));
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("s_pc", 32'(bus.instr_pc_o), 32'(4 * k));
      chk("s_data", bus.instr_o, dat(8'(4 * k)));
    end

    // stall: credits run out after DEPTH grants
    do_reset(1);
    bus.instr_ready_i = 1'b0;
    repeat (4) step();
    chk("st_req4", 32'(bus.mem_req_o), 0);
    chk("st_ngnt4", 32'(ngnt), 4);
    step();
    chk("st_req5", 32'(bus.mem_req_o), 0);
    chk("st_ngnt5", 32'(ngnt), 4);
    chk("st_head", 32'(bus.instr_pc_o), 0);
    bus.instr_ready_i = 1'b1;
    step();
    bus.instr_ready_i = 1'b0;
    chk("st_pop_pc", 32'(bus.instr_pc_o), 4);
    chk("st_req6", 32'(bus.mem_req_o), 1);
    chk("st_addr6", 32'(bus.mem_addr_o), 32'h10);

    // redirect with two requests in flight, latency 3
    do_reset(3);
    step();
    step();
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 8'h40;
    #1;
    chk("rd_req", 32'(bus.mem_req_o), 0);
    step();
    bus.redirect_i = 1'b0;
    chk("rd_addr", 32'(bus.mem_addr_o), 32'h40);
    chk("rd_valid", 32'(bus.instr_valid_o), 0);
    wait_valid("rd");
    bus.instr_ready_i = 1'b0;
    chk("rd_pc", 32'(bus.instr_pc_o), 32'h40);
    chk("rd_data", bus.instr_o, dat(8'h40));
    repeat (5) step();
    chk("rd_hold", 32'(bus.instr_pc_o), 32'h40);
    bus.instr_ready_i = 1'b1;
    step();
    chk("rd_pc2", 32'(bus.instr_pc_o), 32'h44);
    chk("rd_data2", bus.instr_o, dat(8'h44));

    // redirect on a cycle with response and pop pending
    do_reset(1);
    repeat (3) step();
    chk("rx_pre_rv", 32'(bus.mem_rvalid_i), 1);
    chk("rx_pre_v", 32'(bus.instr_valid_o), 1);
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 8'h80;
    #1;
    chk("rx_req", 32'(bus.mem_req_o), 0);
    step();
    bus.redirect_i = 1'b0;
    chk("rx_empty", 32'(bus.instr_valid_o), 0);
    wait_valid("rx");
    chk("rx_pc", 32'(bus.instr_pc_o), 32'h80);
    chk("rx_data", bus.instr_o, dat(8'h80));

    // back-to-back redirects, latency 3
    do_reset(3);
    repeat (3) step();
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 8'h20;
    step();
    bus.redirect_pc_i = 8'h30;
    step();
    bus.redirect_i = 1'b0;
    wait_valid("bb");
    chk("bb_pc", 32'(bus.instr_pc_o), 32'h30);
    chk("bb_data", bus.instr_o, dat(8'h30));

    // PC wrap at 0xFC
    do_reset(1);
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 8'hF8;
    step();
    bus.redirect_i = 1'b0;
    wait_valid("wr");
    chk("wr_pc0", 32'(bus.instr_pc_o), 32'hF8);
    step();
    chk("wr_pc1", 32'(bus.instr_pc_o), 32'hFC);
    chk("wr_data1", bus.instr_o, dat(8'hFC));
    step();
    chk("wr_pc2", 32'(bus.instr_pc_o), 32'h00);
    chk("wr_data2", bus.instr_o, dat(8'h00));
    step();
    chk("wr_pc3", 32'(bus.instr_pc_o), 32'h04);

    // stray response, then async reset mid-burst
    do_reset(1);
    bus.mem_gnt_i = 1'b0;
    step();
    step();
    chk("pe_clean", 32'(bus.protocol_err_o), 0);
    man_rv = 1'b1;
    step();
    man_rv = 1'b0;
    chk("pe_err", 32'(bus.protocol_err_o), 1);
    chk("pe_nopush", 32'(bus.instr_valid_o), 0);
    step();
    chk("pe_sticky", 32'(bus.protocol_err_o), 1);
    bus.mem_gnt_i = 1'b1;
    repeat (4) step();
    chk("ar_valid", 32'(bus.instr_valid_o), 1);
    chk("ar_err", 32'(bus.protocol_err_o), 1);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_req", 32'(bus.mem_req_o), 0);
    chk("ar_v0", 32'(bus.instr_valid_o), 0);
    chk("ar_instr", bus.instr_o, 0);
    chk("ar_pc", 32'(bus.instr_pc_o), 0);
    chk("ar_err0", 32'(bus.protocol_err_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
